// File: rtl/half_adder_if.sv
// Operand/result bundle for the registered half-adder bank.
// The producer drives in_valid/a/b; the adder bank returns out_valid/sum/cout.
interface half_adder_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cout;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/half_adder.sv
// Registered bank of WIDTH independent 1-bit half adders, one-cycle latency with valid strobe.
// Lanes never interact: each lane's {cout,sum} is the 2-bit sum of its a and b bits.
module half_adder #(
    parameter int unsigned WIDTH = 1
) (
    input logic         clk,
    input logic         rst,
    half_adder_if.slave bus
);
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] cout_q;
    logic [WIDTH-1:0] cout_d;
    logic             valid_q;
    logic             valid_d;

    // Idle cycles drop the strobe but keep the last result visible.
    always_comb begin
        valid_d = bus.in_valid;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (bus.in_valid) begin
            sum_d  = bus.a ^ bus.b;
            cout_d = bus.a & bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 banks driven in lockstep, queue scoreboard
// plus directed constant checks.
module tb_half_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    half_adder_if #(.WIDTH(1)) if1 ();
    half_adder_if #(.WIDTH(8)) if8 ();

    half_adder #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    half_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t m1;
    exp_t m8;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next-state of one bank as a function of the stimulus, masked to the bank width.
    function automatic exp_t model(input exp_t cur, input logic r, input logic v,
                                   input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] mask);
        exp_t n;
        n = cur;
        if (r) begin
            n.v = 1'b0;
            n.s = 8'h00;
            n.c = 8'h00;
        end else begin
            n.v = v;
            if (v) begin
                n.s = (a ^ b) & mask;
                n.c = (a & b) & mask;
            end
        end
        return n;
    endfunction

    // Drive one cycle, push expectations, then pop and compare once the edge has passed.
    task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        rst         = r;
        if1.in_valid = v;
        if1.a       = a[0];
        if1.b       = b[0];
        if8.in_valid = v;
        if8.a       = a;
        if8.b       = b;
        m1 = model(m1, r, v, a, b, 8'h01);
        m8 = model(m8, r, v, a, b, 8'hFF);
        q1.push_back(m1);
        q8.push_back(m8);
        @(posedge clk);
        #1;
        if (q1.size() == 0 || q8.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = q1.pop_front();
            chk("sb1_valid", {7'b0, if1.out_valid}, {7'b0, e.v});
            chk("sb1_sum", {7'b0, if1.sum}, e.s);
            chk("sb1_cout", {7'b0, if1.cout}, e.c);
            e = q8.pop_front();
            chk("sb8_valid", {7'b0, if8.out_valid}, {7'b0, e.v});
            chk("sb8_sum", if8.sum, e.s);
            chk("sb8_cout", if8.cout, e.c);
        end
    endtask

    task automatic chk1(input string tag, input logic v, input logic s, input logic c);
        chk({tag, "_valid"}, {7'b0, if1.out_valid}, {7'b0, v});
        chk({tag, "_sum"}, {7'b0, if1.sum}, {7'b0, s});
        chk({tag, "_cout"}, {7'b0, if1.cout}, {7'b0, c});
    endtask

    initial begin
        m1 = '{v: 1'b0, s: 8'h00, c: 8'h00};
        m8 = '{v: 1'b0, s: 8'h00, c: 8'h00};
        rst = 1'b1;
        if1.in_valid = 1'b0;
        if1.a = 1'b0;
        if1.b = 1'b0;
        if8.in_valid = 1'b0;
        if8.a = 8'h00;
        if8.b = 8'h00;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk1("reset", 1'b0, 1'b0, 1'b0);
        chk("reset8_sum", if8.sum, 8'h00);

        // Exhaustive WIDTH=1 truth table
        step(1'b0, 1'b1, 8'h00, 8'h00); chk1("t1_00", 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'h01); chk1("t1_01", 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h01, 8'h00); chk1("t1_10", 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h01, 8'h01); chk1("t1_11", 1'b1, 1'b0, 1'b1);

        // Reset after an accepted 1+1, then a fresh accept
        step(1'b1, 1'b0, 8'h00, 8'h00); chk1("t2_rst", 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 8'h00); chk1("t2_after", 1'b1, 1'b1, 1'b0);

        // Reset wins over a same-cycle accept
        step(1'b1, 1'b1, 8'h01, 8'h01); chk1("t3_prio", 1'b0, 1'b0, 1'b0);

        // Hold: result survives idle cycles while inputs change
        step(1'b0, 1'b1, 8'h00, 8'h01); chk1("t4_acc", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h01, 8'h01);
            chk1($sformatf("t4_hold%0d", i), 1'b0, 1'b1, 1'b0);
        end

        // WIDTH=8 lane independence
        step(1'b0, 1'b1, 8'hF0, 8'hAA);
        chk("t5_sum_a", if8.sum, 8'h5A);
        chk("t5_cout_a", if8.cout, 8'hA0);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        chk("t5_sum_b", if8.sum, 8'h00);
        chk("t5_cout_b", if8.cout, 8'hFF);

        // Random back-to-back traffic with occasional resets
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
